// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: commands, ALU op codes, FSM states.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 32;

  // Request command encodings (8-15 are illegal)
  localparam logic [3:0] CMD_ADD  = 4'd0;
  localparam logic [3:0] CMD_SUB  = 4'd1;
  localparam logic [3:0] CMD_AND  = 4'd2;
  localparam logic [3:0] CMD_OR   = 4'd3;
  localparam logic [3:0] CMD_NOR  = 4'd4;
  localparam logic [3:0] CMD_NAND = 4'd5;
  localparam logic [3:0] CMD_SLT  = 4'd6;
  localparam logic [3:0] CMD_MUL  = 4'd7;

  // ALU operation select
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StMul,
    StDone
  } state_e;

endpackage

// File: rtl/alu_cmd_decode.sv
// Combinational command decoder: cmd -> {invert_a, invert_b, op, legal}.
// Macro ALU_SEQ_MUL_EN makes cmd 7 (MUL) legal; otherwise it decodes as illegal.
module alu_cmd_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] cmd_i,
  output logic       invert_a_o,
  output logic       invert_b_o,
  output logic [1:0] op_o,
  output logic       legal_o
);

  // Table lookup; illegal commands leave every control at zero
  always_comb begin
    invert_a_o = 1'b0;
    invert_b_o = 1'b0;
    op_o       = OP_AND;
    legal_o    = 1'b0;
    unique case (cmd_i)
      CMD_ADD: begin
        op_o    = OP_ADD;
        legal_o = 1'b1;
      end
      CMD_SUB: begin
        invert_b_o = 1'b1;
        op_o       = OP_ADD;
        legal_o    = 1'b1;
      end
      CMD_AND: begin
        op_o    = OP_AND;
        legal_o = 1'b1;
      end
      CMD_OR: begin
        op_o    = OP_OR;
        legal_o = 1'b1;
      end
      CMD_NOR: begin
        invert_a_o = 1'b1;
        invert_b_o = 1'b1;
        op_o       = OP_AND;
        legal_o    = 1'b1;
      end
      CMD_NAND: begin
        invert_a_o = 1'b1;
        invert_b_o = 1'b1;
        op_o       = OP_OR;
        legal_o    = 1'b1;
      end
      CMD_SLT: begin
        invert_b_o = 1'b1;
        op_o       = OP_SLT;
        legal_o    = 1'b1;
      end
`ifdef ALU_SEQ_MUL_EN
      CMD_MUL: begin
        op_o    = OP_ADD;
        legal_o = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequential front end for the combinational 32-bit ALU. Accepts commands over a
// valid/ready handshake, drives the external ALU, returns result and flags.
// Macro ALU_SEQ_MUL_EN enables the shift-add multiply loop (cmd 7) that reuses
// the ALU adder; without it cmd 7 is reported as illegal.
module alu_sequencer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MUL_STEPS = 32
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        req_cmd_i,
  input  logic [DATA_W-1:0] req_src1_i,
  input  logic [DATA_W-1:0] req_src2_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_zero_o,
  output logic              rsp_overflow_o,
  output logic              rsp_err_o,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic              alu_invert_a_o,
  output logic              alu_invert_b_o,
  output logic [1:0]        alu_operation_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  input  logic              alu_overflow_i
);
  import alu_seq_pkg::*;

  state_e            state_q;
  logic [3:0]        cmd_q;
  logic [DATA_W-1:0] src1_q, src2_q;
  logic              rsp_valid_q, rsp_zero_q, rsp_overflow_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_result_q;

  logic              dec_inv_a, dec_inv_b, dec_legal;
  logic [1:0]        dec_op;

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned StepW = $clog2(MUL_STEPS);
  logic [DATA_W-1:0] acc_q, mcand_q, mplier_q;
  logic [StepW-1:0]  step_q;
`endif

  alu_cmd_decode u_decode (
    .cmd_i     (cmd_q),
    .invert_a_o(dec_inv_a),
    .invert_b_o(dec_inv_b),
    .op_o      (dec_op),
    .legal_o   (dec_legal)
  );

  // FSM with latched request, multiply datapath and registered response
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cmd_q          <= '0;
      src1_q         <= '0;
      src2_q         <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_err_q      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q          <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      step_q         <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            cmd_q  <= req_cmd_i;
            src1_q <= req_src1_i;
            src2_q <= req_src2_i;
`ifdef ALU_SEQ_MUL_EN
            if (req_cmd_i == CMD_MUL) begin
              acc_q    <= '0;
              mcand_q  <= req_src1_i;
              mplier_q <= req_src2_i;
              step_q   <= '0;
              state_q  <= StMul;
            end else begin
              state_q  <= StExec;
            end
`else
            state_q <= StExec;
`endif
          end
        end
        StExec: begin
          rsp_valid_q <= 1'b1;
          if (dec_legal) begin
            rsp_result_q   <= alu_result_i;
            rsp_zero_q     <= alu_zero_i;
            rsp_overflow_q <= alu_overflow_i;
            rsp_err_q      <= 1'b0;
          end else begin
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b1;
            rsp_overflow_q <= 1'b0;
            rsp_err_q      <= 1'b1;
          end
          state_q <= StDone;
        end
`ifdef ALU_SEQ_MUL_EN
        StMul: begin
          acc_q    <= alu_result_i;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          step_q   <= step_q + 1'b1;
          // The adder output of the final step is the product
          if (step_q == StepW'(MUL_STEPS - 1)) begin
            rsp_valid_q    <= 1'b1;
            rsp_result_q   <= alu_result_i;
            rsp_zero_q     <= (alu_result_i == '0);
            rsp_overflow_q <= 1'b0;
            rsp_err_q      <= 1'b0;
            state_q        <= StDone;
          end
        end
`endif
        StDone: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // ALU drive: active only in EXEC (legal command) and MUL, zero elsewhere
  always_comb begin
    alu_src1_o      = '0;
    alu_src2_o      = '0;
    alu_invert_a_o  = 1'b0;
    alu_invert_b_o  = 1'b0;
    alu_operation_o = OP_AND;
    unique case (state_q)
      StExec: begin
        if (dec_legal) begin
          alu_src1_o      = src1_q;
          alu_src2_o      = src2_q;
          alu_invert_a_o  = dec_inv_a;
          alu_invert_b_o  = dec_inv_b;
          alu_operation_o = dec_op;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      StMul: begin
        alu_src1_o      = acc_q;
        alu_src2_o      = mplier_q[0] ? mcand_q : '0;
        alu_operation_o = OP_ADD;
      end
`endif
      default: ;
    endcase
  end

  // Gated by rst_n so the block never advertises ready while held in reset
  assign req_ready_o    = rst_n & (state_q == StIdle);
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_result_o   = rsp_result_q;
  assign rsp_zero_o     = rsp_zero_q;
  assign rsp_overflow_o = rsp_overflow_q;
  assign rsp_err_o      = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU and a response scoreboard.
// Latencies are counted in rising edges, the acceptance edge being edge 1.
module tb_alu_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o;
  logic [3:0]  req_cmd_i;
  logic [31:0] req_src1_i, req_src2_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        rsp_zero_o, rsp_overflow_o, rsp_err_o;
  logic [31:0] alu_src1_o, alu_src2_o;
  logic        alu_invert_a_o, alu_invert_b_o;
  logic [1:0]  alu_operation_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i, alu_overflow_i;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk_i = ~clk_i;

  alu_sequencer dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_cmd_i      (req_cmd_i),
    .req_src1_i     (req_src1_i),
    .req_src2_i     (req_src2_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_result_o   (rsp_result_o),
    .rsp_zero_o     (rsp_zero_o),
    .rsp_overflow_o (rsp_overflow_o),
    .rsp_err_o      (rsp_err_o),
    .alu_src1_o     (alu_src1_o),
    .alu_src2_o     (alu_src2_o),
    .alu_invert_a_o (alu_invert_a_o),
    .alu_invert_b_o (alu_invert_b_o),
    .alu_operation_o(alu_operation_o),
    .alu_result_i   (alu_result_i),
    .alu_zero_i     (alu_zero_i),
    .alu_overflow_i (alu_overflow_i)
  );

  // Behavioural combinational ALU (carry-in = invA ^ invB)
  logic [31:0] m_a, m_b, m_sum;
  logic        m_ovf;
  always_comb begin
    m_a   = alu_invert_a_o ? ~alu_src1_o : alu_src1_o;
    m_b   = alu_invert_b_o ? ~alu_src2_o : alu_src2_o;
    m_sum = m_a + m_b + {31'b0, alu_invert_a_o ^ alu_invert_b_o};
    m_ovf = (m_a[31] == m_b[31]) && (m_sum[31] != m_a[31]);
    case (alu_operation_o)
      2'b00:   alu_result_i = m_a & m_b;
      2'b01:   alu_result_i = m_a | m_b;
      2'b10:   alu_result_i = m_sum;
      default: alu_result_i = {31'b0, m_sum[31] ^ m_ovf};
    endcase
    alu_overflow_i = (alu_operation_o == 2'b10) ? m_ovf : 1'b0;
    alu_zero_i     = (alu_result_i == 32'h0);
  end

  // Reference result computed straight from the command semantics
  function automatic exp_t exp_calc(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] r;
    e.ovf = 1'b0;
    e.err = 1'b0;
    e.lat = 2;
    r     = 32'h0;
    case (cmd)
      4'd0: begin r = a + b; e.ovf = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; e.ovf = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = ~(a | b);
      4'd5: r = ~(a & b);
      4'd6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef ALU_SEQ_MUL_EN
      4'd7: begin r = a * b; e.lat = 33; end
`endif
      default: e.err = 1'b1;
    endcase
    e.result = r;
    e.zero   = (r == 32'h0);
    return e;
  endfunction

  // Expected ALU drive during EXEC: {invA, invB, op, src1, src2}
  function automatic logic [67:0] exp_drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    case (cmd)
      4'd0:    return {1'b0, 1'b0, 2'b10, a, b};
      4'd1:    return {1'b0, 1'b1, 2'b10, a, b};
      4'd2:    return {1'b0, 1'b0, 2'b00, a, b};
      4'd3:    return {1'b0, 1'b0, 2'b01, a, b};
      4'd4:    return {1'b1, 1'b1, 2'b00, a, b};
      4'd5:    return {1'b1, 1'b1, 2'b01, a, b};
      4'd6:    return {1'b0, 1'b1, 2'b11, a, b};
      default: return 68'h0;
    endcase
  endfunction

  // One full transaction; hold = cycles to stall rsp_ready_i with checks on stability
  task automatic run_op(input string name, input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input bit chk_drive);
    int   n;
    int   edges;
    exp_t e;
    logic [67:0] drv;
    logic [35:0] snap;
    @(negedge clk_i);
    n = 0;
    while (!req_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    total++;
    if (!req_ready_o) begin
      bad++;
      $display("FAIL %s ready_timeout: req_ready=%b required 1", name, req_ready_o);
    end
    req_valid_i = 1'b1;
    req_cmd_i   = cmd;
    req_src1_i  = a;
    req_src2_i  = b;
    sb.push_back(exp_calc(cmd, a, b));
    @(posedge clk_i);
    edges = 1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_cmd_i   = 4'hF;
    req_src1_i  = 32'hDEAD_BEEF;
    req_src2_i  = 32'h1234_5678;
    if (chk_drive) begin
      drv = {alu_invert_a_o, alu_invert_b_o, alu_operation_o, alu_src1_o, alu_src2_o};
      total++;
      if (drv !== exp_drive(cmd, a, b)) begin
        bad++;
        $display("FAIL %s alu_drive: got %h required %h", name, drv, exp_drive(cmd, a, b));
      end
    end
    while (!rsp_valid_o && edges < 100) begin
      @(posedge clk_i);
      edges++;
      @(negedge clk_i);
    end
    e = sb.pop_front();
    total++;
    if (edges != e.lat) begin
      bad++;
      $display("FAIL %s latency: got %0d edges required %0d", name, edges, e.lat);
    end
    total++;
    if ({rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_overflow_o, rsp_err_o} !==
        {1'b1, e.result, e.zero, e.ovf, e.err}) begin
      bad++;
      $display("FAIL %s response: got v=%b r=%h z=%b o=%b e=%b required v=1 r=%h z=%b o=%b e=%b",
               name, rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_overflow_o, rsp_err_o,
               e.result, e.zero, e.ovf, e.err);
    end
    snap = {rsp_result_o, rsp_zero_o, rsp_overflow_o, rsp_err_o, rsp_valid_o};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      total++;
      if ({rsp_result_o, rsp_zero_o, rsp_overflow_o, rsp_err_o, rsp_valid_o, req_ready_o} !==
          {snap, 1'b0}) begin
        bad++;
        $display("FAIL %s hold_stable[%0d]: got %h/%b required %h/0", name, i,
                 {rsp_result_o, rsp_zero_o, rsp_overflow_o, rsp_err_o, rsp_valid_o},
                 req_ready_o, snap);
      end
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    total++;
    if ({rsp_valid_o, req_ready_o, alu_invert_a_o, alu_invert_b_o, alu_operation_o,
         alu_src1_o, alu_src2_o} !== {1'b0, 1'b1, 68'h0}) begin
      bad++;
      $display("FAIL %s after_complete: rsp_valid=%b req_ready=%b alu_src1=%h required 0,1,0",
               name, rsp_valid_o, req_ready_o, alu_src1_o);
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    req_valid_i = 1'b0;
    req_cmd_i   = 4'h0;
    req_src1_i  = 32'h0;
    req_src2_i  = 32'h0;
    rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    total++;
    if ({req_ready_o, rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_overflow_o, rsp_err_o,
         alu_src1_o, alu_src2_o, alu_invert_a_o, alu_invert_b_o, alu_operation_o} !== 104'h0) begin
      bad++;
      $display("FAIL reset_outputs: req_ready=%b rsp_valid=%b result=%h required all 0",
               req_ready_o, rsp_valid_o, rsp_result_o);
    end
    rst_n = 1'b1;
    @(negedge clk_i);
    total++;
    if ({req_ready_o, rsp_valid_o} !== 2'b10) begin
      bad++;
      $display("FAIL reset_release: req_ready=%b rsp_valid=%b required 1,0", req_ready_o, rsp_valid_o);
    end
  endtask

  task automatic test_sub();
    run_op("sub_5_7", 4'd1, 32'd5, 32'd7, 0, 1'b1);
  endtask

  task automatic test_add_nor();
    run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 0, 1'b1);
    run_op("nor_0_0", 4'd4, 32'h0, 32'h0, 0, 1'b1);
    run_op("and_mix", 4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 1'b1);
    run_op("nand_mix", 4'd5, 32'hFFFF_0000, 32'hFF00_FF00, 0, 1'b1);
    run_op("or_mix", 4'd3, 32'h1200_0000, 32'h0000_0034, 0, 1'b1);
  endtask

  task automatic test_slt();
    run_op("slt_neg", 4'd6, 32'hFFFF_FFFF, 32'd1, 0, 1'b1);
    run_op("slt_swap", 4'd6, 32'd1, 32'hFFFF_FFFF, 0, 1'b1);
  endtask

  task automatic test_mul();
    run_op("mul_12345", 4'd7, 32'd12345, 32'd6789, 0, 1'b0);
    run_op("mul_wrap", 4'd7, 32'h0001_0000, 32'h0001_0000, 0, 1'b0);
  endtask

  task automatic test_illegal_hold();
    run_op("illegal_9", 4'd9, 32'h55, 32'hAA, 5, 1'b1);
  endtask

  // Four responses expected in 12 edges with request and response both always ready
  task automatic test_back_to_back();
    int cnt = 0;
    int overlap = 0;
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_cmd_i   = 4'd0;
    req_src1_i  = 32'd1;
    req_src2_i  = 32'd1;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (rsp_valid_o) begin
        cnt++;
        if (rsp_result_o !== 32'd2 || req_ready_o) overlap++;
      end
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    total++;
    if (cnt != 4 || overlap != 0) begin
      bad++;
      $display("FAIL back_to_back: got %0d responses (%0d bad) required 4 (0 bad)", cnt, overlap);
    end
  endtask

  task automatic test_reset_midop();
    int quiet = 0;
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_cmd_i   = 4'd7;
    req_src1_i  = 32'hFFFF_FFFF;
    req_src2_i  = 32'hFFFF_FFFF;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (9) @(negedge clk_i);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready_o, rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_overflow_o, rsp_err_o,
         alu_src1_o, alu_src2_o, alu_invert_a_o, alu_invert_b_o, alu_operation_o} !== 104'h0) begin
      bad++;
      $display("FAIL midop_reset_outputs: req_ready=%b rsp_valid=%b alu_src1=%h alu_src2=%h required 0",
               req_ready_o, rsp_valid_o, alu_src1_o, alu_src2_o);
    end
    @(negedge clk_i);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o || !req_ready_o) quiet++;
    end
    total++;
    if (quiet != 0) begin
      bad++;
      $display("FAIL midop_no_stale: got %0d busy/valid cycles required 0", quiet);
    end
    run_op("add_after_reset", 4'd0, 32'd2, 32'd3, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_sub();
    test_add_nor();
    test_slt();
    test_mul();
    test_illegal_hold();
    test_back_to_back();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
